multicycle_sequencer: RTL and testbench

//  Main control FSM for the 16-bit multicycle MIPS datapath.

---
 rtl/multicycle_sequencer.sv | 153 +++++++++++++++
 tb/tb_multicycle_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : Main control FSM for the 16-bit multicycle MIPS datapath.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
  parameter int          CNT_W    = 16,
  parameter logic [3:0]  OPC_HALT = 4'b1111
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  output logic [15:0]      ctl_word,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             instr_retired,
  output logic [CNT_W-1:0] instr_count,
  output logic             lcd_start
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_HALT    = 4'd11
  } state_t;

  localparam logic [15:0] c_CTL_FETCH_WAIT = 16'h0088;
  localparam logic [15:0] c_CTL_FETCH_RDY  = 16'h1888;
  localparam logic [15:0] c_CTL_DECODE     = 16'h0018;
  localparam logic [15:0] c_CTL_MEMADDR    = 16'h0014;
  localparam logic [15:0] c_CTL_MEMRD      = 16'h0480;
  localparam logic [15:0] c_CTL_MEMWB      = 16'h0202;
  localparam logic [15:0] c_CTL_MEMWR      = 16'h0500;
  localparam logic [15:0] c_CTL_EXEC       = 16'h0044;
  localparam logic [15:0] c_CTL_RWB        = 16'h0003;
  localparam logic [15:0] c_CTL_BRANCH     = 16'h6024;
  localparam logic [15:0] c_CTL_JUMP       = 16'h9000;

  state_t           r_state;
  state_t           w_next;
  logic             r_one_shot;
  logic             r_is_store;
  logic             r_illegal;
  logic             r_lcd;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      w_ctl;
  logic             w_retire;
  logic             w_set_illegal;

  always_comb begin
    w_next        = r_state;
    w_ctl         = 16'h0000;
    w_retire      = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      S_IDLE:    if (run || step) w_next = S_FETCH;
      S_FETCH: begin
        w_ctl = mem_ready ? c_CTL_FETCH_RDY : c_CTL_FETCH_WAIT;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_ctl = c_CTL_DECODE;
        if (!opcode[3])            w_next = S_EXEC;
        else if (opcode == 4'b1000 || opcode == 4'b1001) w_next = S_MEMADDR;
        else if (opcode == 4'b1010) w_next = S_BRANCH;
        else if (opcode == 4'b1011) w_next = S_JUMP;
        else begin
          w_next        = S_HALT;
          w_set_illegal = (opcode != OPC_HALT);
        end
      end
      S_MEMADDR: begin
        w_ctl  = c_CTL_MEMADDR;
        w_next = r_is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_ctl = c_CTL_MEMRD;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_ctl    = c_CTL_MEMWB;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        w_ctl    = c_CTL_MEMWR;
        w_retire = mem_ready;
      end
      S_EXEC: begin
        w_ctl  = c_CTL_EXEC;
        w_next = S_RWB;
      end
      S_RWB: begin
        w_ctl    = c_CTL_RWB;
        w_retire = 1'b1;
      end
      S_BRANCH: begin
        w_ctl    = c_CTL_BRANCH;
        w_retire = 1'b1;
      end
      S_JUMP: begin
        w_ctl    = c_CTL_JUMP;
        w_retire = 1'b1;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
    // One-shot (stepped) instructions always fall back to IDLE when they retire.
    if (w_retire) w_next = (run && !r_one_shot) ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_one_shot <= 1'b0;
      r_is_store <= 1'b0;
      r_illegal  <= 1'b0;
      r_lcd      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && (run || step)) r_one_shot <= ~run;
      if (r_state == S_DECODE) r_is_store <= (opcode == 4'b1001);
      if (w_set_illegal) r_illegal <= 1'b1;
      r_lcd <= (w_next == S_HALT) && (r_state != S_HALT);
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  assign ctl_word      = w_ctl;
  assign state         = r_state;
  assign halted        = (r_state == S_HALT);
  assign illegal       = r_illegal;
  assign instr_retired = w_retire;
  assign instr_count   = r_count;
  assign lcd_start     = r_lcd;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Purpose  : Self-checking bench for multicycle_sequencer (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

  logic        clock = 1'b0;
  logic        reset, run, step, mem_ready;
  logic [3:0]  opcode;
  logic [15:0] ctl_word, ctl_word4;
  logic [3:0]  state, state4;
  logic        halted, illegal, instr_retired, lcd_start;
  logic        halted4, illegal4, instr_retired4, lcd_start4;
  logic [15:0] instr_count;
  logic [3:0]  instr_count4;

  always #5 clock = ~clock;

  multicycle_sequencer dut (
    .clock(clock), .reset(reset), .run(run), .step(step), .opcode(opcode),
    .mem_ready(mem_ready), .ctl_word(ctl_word), .state(state), .halted(halted),
    .illegal(illegal), .instr_retired(instr_retired), .instr_count(instr_count),
    .lcd_start(lcd_start)
  );

  multicycle_sequencer #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .run(run), .step(step), .opcode(opcode),
    .mem_ready(mem_ready), .ctl_word(ctl_word4), .state(state4), .halted(halted4),
    .illegal(illegal4), .instr_retired(instr_retired4), .instr_count(instr_count4),
    .lcd_start(lcd_start4)
  );

  // Inputs applied for one cycle and the outputs required during that cycle.
  typedef struct {
    logic        rst, run, step, mr;
    logic [3:0]  opc;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic        ret, hlt, ill, lcd;
    logic [15:0] cnt;
  } vec_t;

  vec_t exp_q[$];
  vec_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_n = 0;

  function automatic vec_t mk(input int rst_i, input int run_i, input int step_i,
                              input int mr_i, input int opc_i, input int st_i,
                              input int ctl_i, input int ret_i, input int hlt_i,
                              input int ill_i, input int lcd_i, input int cnt_i);
    vec_t v;
    v.rst = 1'(rst_i); v.run = 1'(run_i); v.step = 1'(step_i); v.mr = 1'(mr_i);
    v.opc = 4'(opc_i); v.st = 4'(st_i); v.ctl = 16'(ctl_i);
    v.ret = 1'(ret_i); v.hlt = 1'(hlt_i); v.ill = 1'(ill_i); v.lcd = 1'(lcd_i);
    v.cnt = 16'(cnt_i);
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clock);
    reset = v.rst; run = v.run; step = v.step; mem_ready = v.mr; opcode = v.opc;
    exp_q.push_back(v);
  endtask

  task automatic drive(input int rst_i, input int run_i, input int step_i, input int mr_i,
                       input int opc_i, input int st_i, input int ctl_i, input int ret_i,
                       input int hlt_i, input int ill_i, input int lcd_i, input int cnt_i);
    apply(mk(rst_i, run_i, step_i, mr_i, opc_i, st_i, ctl_i, ret_i, hlt_i, ill_i, lcd_i, cnt_i));
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc_n, act, req);
    end
  endtask

  always @(negedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state",   {12'b0, state},         {12'b0, e.st});
      chk("ctl",     ctl_word,               e.ctl);
      chk("retired", {15'b0, instr_retired}, {15'b0, e.ret});
      chk("halted",  {15'b0, halted},        {15'b0, e.hlt});
      chk("illegal", {15'b0, illegal},       {15'b0, e.ill});
      chk("lcd",     {15'b0, lcd_start},     {15'b0, e.lcd});
      chk("count",   instr_count,            e.cnt);
      chk("count4",  {12'b0, instr_count4},  e.cnt & 16'h000F);
      cyc_n++;
    end
  end

  vec_t tbl[10];
  int   ec;

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; mem_ready = 1'b0; opcode = 4'h0;
    repeat (2) @(negedge clock);

    // R-type free-run, then run dropped mid-instruction.
    //           rst run stp mr opc  st  ctl     ret hlt ill lcd cnt
    tbl[0] = mk(0, 1, 0, 1, 1,   0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 1, 0, 1, 1,   1, 16'h1888, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 1, 0, 1, 1,   2, 16'h0018, 0, 0, 0, 0, 0);
    tbl[3] = mk(0, 1, 0, 1, 1,   7, 16'h0044, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 1, 0, 1, 1,   8, 16'h0003, 1, 0, 0, 0, 0);
    tbl[5] = mk(0, 0, 0, 1, 1,   1, 16'h1888, 0, 0, 0, 0, 1);
    tbl[6] = mk(0, 0, 0, 1, 1,   2, 16'h0018, 0, 0, 0, 0, 1);
    tbl[7] = mk(0, 0, 0, 1, 1,   7, 16'h0044, 0, 0, 0, 0, 1);
    tbl[8] = mk(0, 0, 0, 1, 1,   8, 16'h0003, 1, 0, 0, 0, 1);
    tbl[9] = mk(0, 0, 0, 1, 1,   0, 16'h0000, 0, 0, 0, 0, 2);
    for (int i = 0; i < 10; i++) apply(tbl[i]);

    // lw with a fetch wait and two MEMRD wait cycles.
    drive(0, 1, 0, 1, 8,  0, 16'h0000, 0, 0, 0, 0, 2);
    drive(0, 1, 0, 0, 8,  1, 16'h0088, 0, 0, 0, 0, 2);
    drive(0, 1, 0, 1, 8,  1, 16'h1888, 0, 0, 0, 0, 2);
    drive(0, 1, 0, 1, 8,  2, 16'h0018, 0, 0, 0, 0, 2);
    drive(0, 1, 0, 1, 8,  3, 16'h0014, 0, 0, 0, 0, 2);
    drive(0, 1, 0, 0, 8,  4, 16'h0480, 0, 0, 0, 0, 2);
    drive(0, 1, 0, 0, 8,  4, 16'h0480, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 1, 8,  4, 16'h0480, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 1, 8,  5, 16'h0202, 1, 0, 0, 0, 2);
    drive(0, 0, 0, 1, 8,  0, 16'h0000, 0, 0, 0, 0, 3);

    // Single-step sw with a write wait; step while busy is ignored.
    drive(0, 0, 1, 1, 9,  0, 16'h0000, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 9,  1, 16'h1888, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 9,  2, 16'h0018, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 9,  3, 16'h0014, 0, 0, 0, 0, 3);
    drive(0, 0, 0, 0, 9,  6, 16'h0500, 0, 0, 0, 0, 3);
    drive(0, 0, 1, 1, 9,  6, 16'h0500, 1, 0, 0, 0, 3);
    drive(0, 0, 0, 1, 9,  0, 16'h0000, 0, 0, 0, 0, 4);
    drive(0, 0, 0, 1, 9,  0, 16'h0000, 0, 0, 0, 0, 4);
    // Second step; run raised on the retire cycle must not continue a one-shot.
    drive(0, 0, 1, 1, 9,  0, 16'h0000, 0, 0, 0, 0, 4);
    drive(0, 0, 0, 1, 9,  1, 16'h1888, 0, 0, 0, 0, 4);
    drive(0, 0, 0, 1, 9,  2, 16'h0018, 0, 0, 0, 0, 4);
    drive(0, 0, 0, 1, 9,  3, 16'h0014, 0, 0, 0, 0, 4);
    drive(0, 1, 0, 1, 9,  6, 16'h0500, 1, 0, 0, 0, 4);
    drive(0, 0, 0, 1, 9,  0, 16'h0000, 0, 0, 0, 0, 5);

    // run+step together free-runs: beq then j.
    drive(0, 1, 1, 1, 10, 0, 16'h0000, 0, 0, 0, 0, 5);
    drive(0, 1, 0, 1, 10, 1, 16'h1888, 0, 0, 0, 0, 5);
    drive(0, 1, 0, 1, 10, 2, 16'h0018, 0, 0, 0, 0, 5);
    drive(0, 1, 0, 1, 11, 9, 16'h6024, 1, 0, 0, 0, 5);
    drive(0, 1, 0, 1, 11, 1, 16'h1888, 0, 0, 0, 0, 6);
    drive(0, 1, 0, 1, 11, 2, 16'h0018, 0, 0, 0, 0, 6);
    drive(0, 0, 0, 1, 11, 10, 16'h9000, 1, 0, 0, 0, 6);
    drive(0, 0, 0, 1, 11, 0, 16'h0000, 0, 0, 0, 0, 7);

    // 16 back-to-back R-types: the 4-bit counter wraps 15 -> 0.
    ec = 7;
    drive(0, 1, 0, 1, 2, 0, 16'h0000, 0, 0, 0, 0, ec);
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 0, 1, 2, 1, 16'h1888, 0, 0, 0, 0, ec);
      drive(0, 1, 0, 1, 2, 2, 16'h0018, 0, 0, 0, 0, ec);
      drive(0, 1, 0, 1, 2, 7, 16'h0044, 0, 0, 0, 0, ec);
      drive(0, (k == 15) ? 0 : 1, 0, 1, 2, 8, 16'h0003, 1, 0, 0, 0, ec);
      ec++;
    end
    drive(0, 0, 0, 1, 2, 0, 16'h0000, 0, 0, 0, 0, ec);

    // Reset during a fetch wait.
    drive(0, 1, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, ec);
    drive(0, 1, 0, 0, 1, 1, 16'h0088, 0, 0, 0, 0, ec);
    drive(1, 1, 0, 0, 1, 1, 16'h0088, 0, 0, 0, 0, ec);
    drive(0, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 0);

    // Illegal opcode: HALT absorbs run/step, lcd_start pulses once.
    drive(0, 1, 0, 1, 13, 0,  16'h0000, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 13, 1,  16'h1888, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 13, 2,  16'h0018, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 13, 11, 16'h0000, 0, 1, 1, 1, 0);
    drive(0, 0, 1, 1, 13, 11, 16'h0000, 0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 1,  11, 16'h0000, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 1, 1,  11, 16'h0000, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 1,  0,  16'h0000, 0, 0, 0, 0, 0);

    // Legal HALT opcode after one R-type: not illegal, not counted.
    drive(0, 1, 0, 1, 1,  0,  16'h0000, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1,  1,  16'h1888, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1,  2,  16'h0018, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1,  7,  16'h0044, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 1,  8,  16'h0003, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 15, 1,  16'h1888, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 15, 2,  16'h0018, 0, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 15, 11, 16'h0000, 0, 1, 0, 1, 1);
    drive(0, 1, 0, 1, 15, 11, 16'h0000, 0, 1, 0, 0, 1);
    drive(0, 0, 1, 1, 15, 11, 16'h0000, 0, 1, 0, 0, 1);

    repeat (2) @(negedge clock);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
